// File: rtl/hpdc_mem_read_responder.sv
// Memory-side read responder for the HPDcache: queues read requests and
// returns len+1 beat bursts from a preloadable line-wide storage array.
module hpdc_mem_read_responder #(
    parameter int DATA_W      = 512,
    parameter int ID_W        = 8,
    parameter int ADDR_W      = 49,
    parameter int MEM_DEPTH   = 1024,
    parameter int OUTSTANDING = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         mem_req_valid_i,
    output logic                         mem_req_ready_o,
    input  logic [ADDR_W-1:0]            mem_req_addr_i,
    input  logic [7:0]                   mem_req_len_i,
    input  logic [2:0]                   mem_req_size_i,
    input  logic [ID_W-1:0]              mem_req_id_i,
    input  logic [1:0]                   mem_req_command_i,
    input  logic                         mem_req_cacheable_i,
    output logic                         mem_resp_r_valid_o,
    input  logic                         mem_resp_r_ready_i,
    output logic                         mem_resp_r_error_o,
    output logic [ID_W-1:0]              mem_resp_r_id_o,
    output logic [DATA_W-1:0]            mem_resp_r_data_o,
    output logic                         mem_resp_r_last_o,
    input  logic                         init_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] init_addr_i,
    input  logic [DATA_W-1:0]            init_data_i
);
    // state | meaning
    // IDLE  | next issue sends beat 0 of the FIFO head
    // BURST | next issue sends beat cnt of the FIFO head
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int PTR_W  = $clog2(OUTSTANDING);

    typedef enum logic {IDLE, BURST} state_t;

    state_t state;
    logic [7:0] cnt;

    logic [IDX_W-1:0]  fifo_base [OUTSTANDING];
    logic [7:0]        fifo_len  [OUTSTANDING];
    logic [ID_W-1:0]   fifo_id   [OUTSTANDING];
    logic [1:0]        fifo_cmd  [OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              full, empty, push, pop, issue;
    logic [IDX_W-1:0]  head_base, beat_idx;
    logic [7:0]        head_len, beat_num;
    logic [ID_W-1:0]   head_id;
    logic [1:0]        head_cmd;
    logic              is_read, in_range, beat_last, beat_err;
    logic [DATA_W-1:0] beat_data;
    logic              unused_ok;

    assign unused_ok = ^{mem_req_size_i, mem_req_cacheable_i, mem_req_addr_i[OFF_W-1:0]};

    assign full            = (count == (PTR_W+1)'(OUTSTANDING));
    assign empty           = (count == '0);
    assign mem_req_ready_o = !full;
    assign push            = mem_req_valid_i && !full;
    assign issue           = !empty && (!mem_resp_r_valid_o || mem_resp_r_ready_i);

    assign head_base = fifo_base[rd_ptr];
    assign head_len  = fifo_len[rd_ptr];
    assign head_id   = fifo_id[rd_ptr];
    assign head_cmd  = fifo_cmd[rd_ptr];

    // Index wraps only at the full address-space width, never inside MEM_DEPTH.
    assign beat_num  = (state == BURST) ? cnt : 8'd0;
    assign beat_idx  = head_base + IDX_W'(beat_num);
    assign in_range  = (beat_idx[IDX_W-1:MEM_AW] == '0);
    assign is_read   = (head_cmd == 2'd0);
    assign beat_last = !is_read || (beat_num == head_len);
    assign beat_err  = !is_read || !in_range;
    assign beat_data = beat_err ? '0 : mem[beat_idx[MEM_AW-1:0]];
    assign pop       = issue && beat_last;

    always_ff @(posedge clk_i) begin
        if (init_we_i) mem[init_addr_i] <= init_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_base[wr_ptr] <= mem_req_addr_i[ADDR_W-1:OFF_W];
            fifo_len[wr_ptr]  <= mem_req_len_i;
            fifo_id[wr_ptr]   <= mem_req_id_i;
            fifo_cmd[wr_ptr]  <= mem_req_command_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= IDLE;
            cnt                <= 8'd0;
            mem_resp_r_valid_o <= 1'b0;
            mem_resp_r_error_o <= 1'b0;
            mem_resp_r_id_o    <= '0;
            mem_resp_r_data_o  <= '0;
            mem_resp_r_last_o  <= 1'b0;
        end else if (issue) begin
            mem_resp_r_valid_o <= 1'b1;
            mem_resp_r_error_o <= beat_err;
            mem_resp_r_id_o    <= head_id;
            mem_resp_r_data_o  <= beat_data;
            mem_resp_r_last_o  <= beat_last;
            if (pop) begin
                state <= IDLE;
                cnt   <= 8'd0;
            end else begin
                state <= BURST;
                cnt   <= beat_num + 8'd1;
            end
        end else if (mem_resp_r_ready_i) begin
            mem_resp_r_valid_o <= 1'b0;
        end
    end
endmodule
